// File: rtl/warp_imem_responder_if.sv
// Fetch-request handshake between the warp controller and the instruction
// memory responder.
//   mem_req    : controller asks for a kernel fetch
//   req_addr   : kernel start byte address (word aligned when legal)
//   req_length : number of 32-bit instructions to fetch
//   mem_ready  : responder can accept a request this cycle
//   mem_valid  : one-cycle pulse, burst finished successfully
//   mem_error  : one-cycle pulse, request was rejected
// The controller side uses the master modport, the responder the slave one.
interface warp_imem_responder_if;
  logic        mem_req;
  logic [31:0] req_addr;
  logic [15:0] req_length;
  logic        mem_ready;
  logic        mem_valid;
  logic        mem_error;

  modport master (
    output mem_req, req_addr, req_length,
    input  mem_ready, mem_valid, mem_error
  );

  modport slave (
    input  mem_req, req_addr, req_length,
    output mem_ready, mem_valid, mem_error
  );
endinterface

// File: rtl/warp_imem_responder.sv
// Instruction memory responder: accepts a kernel fetch (byte address + word
// count), reads the words from a single-port SRAM with 1-cycle read latency
// and pushes them, in ascending address order, into the instruction FIFO.
// A 2-entry buffer plus an in-flight flag absorbs FIFO backpressure without
// dropping or duplicating words.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   fetch       : request handshake (slave side)
//   sram_en     : SRAM read enable
//   sram_addr   : SRAM word address
//   sram_rdata  : SRAM read data, valid the cycle after sram_en
//   fifo_push   : FIFO push strobe (held while fifo_full)
//   fifo_wdata  : FIFO push data (buffer head)
//   fifo_full   : FIFO full; a push happens only when fifo_push && !fifo_full
//   busy        : responder is not idle
//   words_sent  : words pushed in the current or last burst
module warp_imem_responder #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  warp_imem_responder_if.slave fetch,
  output logic                 sram_en,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [31:0]          sram_rdata,
  output logic                 fifo_push,
  output logic [31:0]          fifo_wdata,
  input  logic                 fifo_full,
  output logic                 busy,
  output logic [15:0]          words_sent
);

  typedef enum logic [1:0] {IDLE, READ, DONE, ERROR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] rd_ptr;
  logic [15:0]       rd_left;
  logic [15:0]       push_left;
  logic [31:0]       buf_data [2];
  logic              buf_head;
  logic [1:0]        buf_count;
  logic              inflight;

  logic        push_fire;
  logic [2:0]  occ_after;
  logic [32:0] range_end;
  logic        reject;
  logic        accept_ok;
  logic        accept_read;
  logic        ready, valid, error;
  logic        wr_idx;

  assign push_fire  = fifo_push && !fifo_full;
  // Buffer occupancy once this cycle's pop is taken and the in-flight word
  // lands; a new read is only safe if it will still find a free slot.
  assign occ_after  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, push_fire};

  // 33-bit sum so a huge start address plus length cannot wrap into range.
  assign range_end  = {3'b000, fetch.req_addr[31:2]} + {17'd0, fetch.req_length};
  assign reject     = (fetch.req_addr[1:0] != 2'b00) || (range_end > 33'(IMEM_DEPTH));

  assign accept_ok   = (state == IDLE) && fetch.mem_req && !reject;
  assign accept_read = accept_ok && (fetch.req_length != 16'd0);

  assign fifo_push  = (buf_count != 2'd0);
  assign fifo_wdata = buf_data[buf_head];
  assign sram_addr  = rd_ptr;
  // An arriving word never finds more than one slot occupied, so the free
  // slot sits directly behind the head.
  assign wr_idx     = buf_head ^ buf_count[0];

  assign fetch.mem_ready = ready;
  assign fetch.mem_valid = valid;
  assign fetch.mem_error = error;
  assign busy            = !ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_next = state;
    ready      = 1'b0;
    valid      = 1'b0;
    error      = 1'b0;
    sram_en    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (fetch.mem_req) begin
          if (reject)                          state_next = ERROR;
          else if (fetch.req_length == 16'd0)  state_next = DONE;
          else                                 state_next = READ;
        end
      end
      READ: begin
        sram_en = (rd_left != 16'd0) && (occ_after < 3'd2);
        if (push_fire && (push_left == 16'd1)) state_next = DONE;
      end
      DONE: begin
        valid      = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        error      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      rd_left     <= '0;
      push_left   <= '0;
      words_sent  <= '0;
      buf_head    <= 1'b0;
      buf_count   <= 2'd0;
      inflight    <= 1'b0;
      // NOTE: the buffer is just two flops, cleared so fifo_wdata reads zero
      // out of reset; a real RAM array would not be reset.
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      state <= state_next;

      if (accept_read) begin
        rd_ptr    <= fetch.req_addr[ADDR_W+1:2];
        rd_left   <= fetch.req_length;
        push_left <= fetch.req_length;
      end else begin
        if (sram_en) begin
          rd_ptr  <= rd_ptr + 1'b1;
          rd_left <= rd_left - 1'b1;
        end
        if (push_fire) push_left <= push_left - 1'b1;
      end

      if (accept_ok)      words_sent <= '0;
      else if (push_fire) words_sent <= words_sent + 1'b1;

      if (inflight) buf_data[wr_idx] <= sram_rdata;
      buf_count <= buf_count + {1'b0, inflight} - {1'b0, push_fire};
      buf_head  <= buf_head ^ push_fire;
      inflight  <= sram_en;
    end
  end

endmodule

// File: tb/tb_warp_imem_responder.sv
// Self-checking bench for warp_imem_responder. A behavioural SRAM feeds the
// DUT; the expected push stream is built from the memory image and request,
// and a negedge monitor scores pushes, pulses, timing and backpressure rules.
module tb_warp_imem_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sram_en;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;
  logic          fifo_push;
  logic [31:0]   fifo_wdata;
  logic          fifo_full;
  logic          busy;
  logic [15:0]   words_sent;

  warp_imem_responder_if fetch_if ();

  warp_imem_responder #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch      (fetch_if.slave),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .fifo_push  (fifo_push),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM, one-cycle read latency.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (sram_en) sram_rdata <= mem[sram_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard state shared by the monitor and the sequences.
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          in_burst = 0;
  int          mon_rel;
  int          pushes, reads, valids, errors, accepts;
  int          first_push_rel, valid_rel, error_rel, ready_rel, valid_cyc, ready_viol;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic [31:0] exp_q [$];
  int          full_mode = 0;
  int          win_lo = 0, win_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    mon_rel = cyc - acc_cyc + 1;
    if (prev_stall) begin
      check("hold_push", fifo_push, 1'b1);
      check("hold_data", fifo_wdata, prev_data);
    end
    prev_stall = fifo_push && fifo_full;
    prev_data  = fifo_wdata;
    if (fifo_push && !fifo_full) begin
      if (exp_q.size() == 0) check("push_expected", exp_q.size() != 0, 1'b1);
      else                   check("push_data", fifo_wdata, exp_q.pop_front());
      if (pushes == 0) first_push_rel = mon_rel;
      pushes++;
    end
    if (sram_en) begin
      reads++;
      check("read_ahead", (reads - pushes) <= 2, 1'b1);
    end
    if (fetch_if.mem_valid) begin valids++; valid_rel = mon_rel; valid_cyc = cyc; end
    if (fetch_if.mem_error) begin errors++; error_rel = mon_rel; end
    if (fetch_if.mem_ready == busy) ready_viol++;
    if (in_burst && fetch_if.mem_ready) begin ready_rel = mon_rel; in_burst = 0; end
    if (fetch_if.mem_req && fetch_if.mem_ready) begin
      acc_cyc  = cyc + 1;
      in_burst = 1;
      accepts++;
    end
  end

  // FIFO backpressure: none, random, or a window of cycles after accept.
  initial begin
    fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        1:       fifo_full = ($urandom_range(0, 2) == 0);
        2:       fifo_full = in_burst && ((cyc - acc_cyc + 1) >= win_lo) && ((cyc - acc_cyc + 1) <= win_hi);
        default: fifo_full = 1'b0;
      endcase
    end
  end

  task automatic clear_counts();
    pushes = 0; reads = 0; valids = 0; errors = 0; accepts = 0;
    first_push_rel = -1; valid_rel = -1; error_rel = -1; ready_rel = -1;
    valid_cyc = -1; ready_viol = 0; prev_stall = 0;
    exp_q.delete();
  endtask

  task automatic load_expected(input logic [31:0] addr, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(addr >> 2) + i]);
  endtask

  task automatic check_reset_values();
    check("rst_mem_ready", fetch_if.mem_ready, 1'b1);
    check("rst_mem_valid", fetch_if.mem_valid, 1'b0);
    check("rst_mem_error", fetch_if.mem_error, 1'b0);
    check("rst_sram_en", sram_en, 1'b0);
    check("rst_sram_addr", sram_addr, '0);
    check("rst_fifo_push", fifo_push, 1'b0);
    check("rst_fifo_wdata", fifo_wdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_words_sent", words_sent, '0);
  endtask

  // Wait (bounded) until the monitor has seen `n` accepts.
  task automatic wait_accepts(input int n, input string tag);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (accepts >= n) ok = 1;
    end
    check(tag, ok, 1'b1);
  endtask

  // Wait (bounded) until `n` completions were seen and the DUT is idle again.
  task automatic wait_finished(input int n, input string tag);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      if ((valids + errors) >= n && !in_burst) ok = 1;
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic run_burst(input logic [31:0] addr, input int len, input int mode,
                           input int lo, input int hi);
    bit     err;
    longint wend;
    int     end_rel;
    wend = longint'(addr >> 2) + longint'(len);
    err  = (addr[1:0] != 2'b00) || (wend > DEPTH);
    clear_counts();
    if (!err) load_expected(addr, len);
    full_mode = mode; win_lo = lo; win_hi = hi;
    @(posedge clk); #1;
    fetch_if.mem_req    = 1'b1;
    fetch_if.req_addr   = addr;
    fetch_if.req_length = 16'(len);
    wait_accepts(1, "accept_seen");
    @(posedge clk); #1;
    fetch_if.mem_req = 1'b0;
    wait_finished(1, "burst_finished");
    repeat (2) @(negedge clk);
    #1;
    full_mode = 0;
    check("accepts", accepts, 1);
    if (err) begin
      check("err_pulses", errors, 1);
      check("err_rel", error_rel, 1);
      check("err_reads", reads, 0);
      check("err_pushes", pushes, 0);
      check("err_valids", valids, 0);
      end_rel = error_rel;
    end else begin
      check("valids", valids, 1);
      check("errors", errors, 0);
      check("pushes", pushes, len);
      check("reads", reads, len);
      check("left_over", exp_q.size(), 0);
      if (len > 0) check("words_sent", words_sent, 16'(len));
      if (len == 0) check("zero_valid_rel", valid_rel, 1);
      if (mode == 0 && len > 0) begin
        check("first_push_rel", first_push_rel, 3);
        check("valid_rel", valid_rel, len + 3);
      end
      end_rel = valid_rel;
    end
    check("ready_rel", ready_rel, end_rel + 1);
    check("ready_vs_busy", ready_viol, 0);
  endtask

  initial begin
    int v1;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEBABE;
    mem[2] = 32'h12345678;
    mem[3] = 32'h0BADF00D;

    rst_n = 1'b0;
    fetch_if.mem_req    = 1'b0;
    fetch_if.req_addr   = '0;
    fetch_if.req_length = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_values();
    rst_n = 1'b1;

    // Directed bursts.
    run_burst(32'h0,   4, 0, 0, 0);
    run_burst(32'h10,  6, 2, 4, 8);
    run_burst(32'h40,  0, 0, 0, 0);
    run_burst(32'h2,   1, 0, 0, 0);
    run_burst(32'hFFC, 2, 0, 0, 0);
    run_burst(32'hFF0, 4, 0, 0, 0);

    // Reset in the middle of an 8-word burst, after two pushes.
    clear_counts();
    load_expected(32'h20, 8);
    @(posedge clk); #1;
    fetch_if.mem_req = 1'b1; fetch_if.req_addr = 32'h20; fetch_if.req_length = 16'd8;
    wait_accepts(1, "rst_accept_seen");
    @(posedge clk); #1;
    fetch_if.mem_req = 1'b0;
    begin
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk); #1;
        if (pushes >= 2) ok = 1;
      end
      check("two_pushes_seen", ok, 1'b1);
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_reset_values();
    rst_n = 1'b1;
    clear_counts();
    repeat (10) @(negedge clk);
    #1;
    check("post_rst_pushes", pushes, 0);
    check("post_rst_reads", reads, 0);
    check("post_rst_valids", valids, 0);
    run_burst(32'h30, 2, 0, 0, 0);

    // Request held high across two back-to-back bursts.
    clear_counts();
    load_expected(32'h100, 3);
    load_expected(32'h200, 2);
    @(posedge clk); #1;
    fetch_if.mem_req = 1'b1; fetch_if.req_addr = 32'h100; fetch_if.req_length = 16'd3;
    begin
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk); #1;
        if (valids >= 1) ok = 1;
      end
      check("b2b_first_valid", ok, 1'b1);
    end
    v1 = valid_cyc;
    fetch_if.req_addr = 32'h200; fetch_if.req_length = 16'd2;
    wait_accepts(2, "b2b_second_accept");
    @(posedge clk); #1;
    fetch_if.mem_req = 1'b0;
    wait_finished(2, "b2b_finished");
    check("b2b_accepts", accepts, 2);
    check("b2b_accept_cycle", acc_cyc, v1 + 2);
    check("b2b_valids", valids, 2);
    check("b2b_pushes", pushes, 5);
    check("b2b_left_over", exp_q.size(), 0);
    check("b2b_words_sent", words_sent, 16'd2);
    check("b2b_ready_vs_busy", ready_viol, 0);

    // Randomized requests with random backpressure.
    for (int t = 0; t < 24; t++) begin
      int          kind, wa, len, mode;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      mode = $urandom_range(0, 1);
      if (kind == 0) begin
        wa = $urandom_range(0, 1000); len = $urandom_range(1, 8);
        addr = (32'(wa) << 2) | 32'($urandom_range(1, 3));
      end else if (kind == 1) begin
        wa = $urandom_range(1015, 1023); len = $urandom_range(10, 40);
        addr = 32'(wa) << 2;
      end else begin
        wa = $urandom_range(0, 1000); len = $urandom_range(0, 12);
        addr = 32'(wa) << 2;
      end
      run_burst(addr, len, mode, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
